// File: rtl/mem_responder.sv
// Word-addressed memory slave on a valid/ready bus with programmable latency.
// Define MEM_RESPONDER_STATS_EN to enable the read/write/fetch counters.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        addr_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] fetch_count
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_TURN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_fire;
    logic          w_live;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic          w_instr;
    logic [31:0]   w_word;
    logic          w_inrange;
    logic          w_is_rd;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_next = r_state;
        w_fire = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    if (LATENCY == 0) begin
                        // r_run keeps a zero-latency write from firing while reset is held
                        if (r_run) begin
                            w_next = S_RESPOND;
                            w_fire = 1'b1;
                        end
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = S_RESPOND;
                    w_fire = 1'b1;
                end
            end
            S_RESPOND: w_next = S_TURN;
            S_TURN:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Zero latency responds on the capture edge, so live inputs are used there
    assign w_live    = (r_state == S_IDLE);
    assign w_addr    = w_live ? mem_addr  : r_addr;
    assign w_wdata   = w_live ? mem_wdata : r_wdata;
    assign w_wstrb   = w_live ? mem_wstrb : r_wstrb;
    assign w_instr   = w_live ? mem_instr : r_instr;
    assign w_word    = w_addr >> 2;
    assign w_inrange = (w_word < 32'(DEPTH_WORDS));
    assign w_idx     = w_word[AW-1:0];
    assign w_is_rd   = (w_wstrb == 4'b0000);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_run   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_instr <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (r_state == S_IDLE && mem_valid) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_wstrb <= mem_wstrb;
                r_instr <= mem_instr;
                r_cnt   <= 4'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire) begin
                if (w_is_rd) begin
                    r_rdata <= w_inrange ? r_mem[w_idx] : 32'd0;
                end
                if (!w_inrange) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_inrange && !w_is_rd) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = (r_state == S_RESPOND);
    assign mem_rdata = r_rdata;
    assign addr_err  = r_err;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_fe_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
            r_fe_cnt <= 32'd0;
        end else if (w_fire) begin
            if (w_is_rd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
                if (w_instr) begin
                    r_fe_cnt <= r_fe_cnt + 32'd1;
                end
            end else begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_count    = r_rd_cnt;
    assign wr_count    = r_wr_cnt;
    assign fetch_count = r_fe_cnt;
`else
    logic w_unused;

    assign w_unused    = w_instr;
    assign rd_count    = 32'd0;
    assign wr_count    = 32'd0;
    assign fetch_count = 32'd0;
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, wait cycles inserted before mem_ready (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mem_valid  input  1  request from initiator, held high until mem_ready is seen.
REQ-006 SHALL have port mem_instr  input  1  request is an instruction fetch.
REQ-007 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have port mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port mem_wdata  input  32  write data, byte lanes aligned to mem_wstrb.
REQ-010 SHALL have port mem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_ready is high.
REQ-012 SHALL have port addr_err  output  1  sticky flag: an out-of-range access occurred.
REQ-013 SHALL have ports rd_count, wr_count, fetch_count  output  32 each  access counters (see Configuration).

Function
REQ-014 SHALL implement states IDLE, WAIT, RESPOND, TURN.
REQ-015 IDLE: on an edge with mem_valid=1, SHALL capture addr/wdata/wstrb/instr, load wait counter with LATENCY, go to WAIT (LATENCY>0) or RESPOND (LATENCY=0).
REQ-016 WAIT: SHALL decrement counter each edge; at 1 go to RESPOND; if mem_valid is 0 at any edge, SHALL abort to IDLE with no memory write and no pulse.
REQ-017 Transition into RESPOND: SHALL assert mem_ready for exactly one cycle, perform the write or the registered read on that same edge, then go to TURN.
REQ-018 Latency: mem_ready SHALL be high in the cycle starting LATENCY+1 edges after mem_valid is first sampled high.
REQ-019 TURN: SHALL ignore mem_valid for one cycle, then return to IDLE; back-to-back requests therefore take LATENCY+3 cycles minimum.
REQ-020 Word index SHALL be mem_addr[31:2]; in range iff index < DEPTH_WORDS.
REQ-021 In-range write SHALL update only the byte lanes whose mem_wstrb bit is 1; other bytes unchanged.
REQ-022 In-range read SHALL return the full stored word; mem_rdata SHALL hold its value until the next response.
REQ-023 Out-of-range access SHALL still complete with mem_ready, return mem_rdata=0, drop writes, set addr_err.
REQ-024 Captured request fields SHALL be used, so input changes after capture do not affect the response.

Reset
REQ-025 resetn=0 SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, addr_err=0, counters=0.
REQ-026 Reset mid-operation SHALL abandon the request without a write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro MEM_RESPONDER_STATS_EN defined: rd_count/wr_count/fetch_count SHALL increment on each completed read/write/fetch (fetch also counts as read), wrapping at 2^32.
REQ-028 Macro undefined: counter ports SHALL exist and be tied to 0, with no counter logic.

Verification
REQ-029 LATENCY=1: write 0x12345678 to 0x10 with wstrb 4'b1111, then read 0x10 -> mem_ready 2 cycles after valid, mem_rdata=0x12345678.
REQ-030 Word at 0x20 holds 0xAABBCCDD; write wdata 0x11111111 wstrb 4'b0101 -> subsequent read returns 0xAA11CC11.
REQ-031 DEPTH_WORDS=1024: read 0x00001000 -> mem_ready pulse, mem_rdata=0, addr_err=1 and stays 1; write there leaves word 0 unchanged.
REQ-032 LATENCY=3: drop mem_valid after 2 cycles -> no mem_ready, memory unchanged, state IDLE; new request then served normally.
REQ-033 Assert resetn=0 asynchronously during WAIT of a write -> mem_ready=0 at once, no write; prior data still readable after release.
REQ-034 With MEM_RESPONDER_STATS_EN: 2 fetches, 1 data read, 3 writes -> fetch_count=2, rd_count=3, wr_count=3; without macro all read 0.
